// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - opcodes, FSM encoding and golden gate function for the response checker
package gate_check_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUF  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // BUF and NOT look at in1 only; in2 is a don't-care for them.
  function automatic logic gate_expect(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_BUF:  r = a;
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden model of the gate under check
module gate_ref_model
  import gate_check_pkg::*;
#(
  parameter logic [2:0] GATE_OP = OP_XOR
) (
  input  logic in1,
  input  logic in2,
  output logic expected
);

  assign expected = gate_expect(GATE_OP, in1, in2);

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - checks DUT gate responses, counts errors, tracks coverage
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter logic [2:0]  GATE_OP     = OP_XOR,
  parameter int unsigned NUM_VECTORS = 20,
  parameter int unsigned ERR_W       = 8,
  localparam int unsigned VEC_W      = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             in1,
  input  logic             in2,
  input  logic             out_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] vec_count,
  output logic [VEC_W-1:0] first_err_idx,
  output logic [2:0]       first_err_vec,
  output logic [3:0]       coverage
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] fidx_q, fidx_d;
  logic [2:0]       fvec_q, fvec_d;
  logic [3:0]       cov_q, cov_d;
  logic             pass_q, pass_d;
  logic             expected;
  logic             accept;
  logic             clear;

  gate_ref_model #(.GATE_OP(GATE_OP)) u_ref (
    .in1      (in1),
    .in2      (in2),
    .expected (expected)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvec_q  <= '0;
      cov_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvec_q  <= fvec_d;
      cov_q   <= cov_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fvec_d  = fvec_q;
    cov_d   = cov_q;
    pass_d  = pass_q;
    accept  = 1'b0;
    clear   = 1'b0;

    // start always wins over a sample offered in the same cycle
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (start) clear = 1'b1;
        else if (sample_valid) accept = 1'b1;
      end
      ST_DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      vec_d  = '0;
      err_d  = '0;
      fidx_d = '0;
      fvec_d = '0;
      cov_d  = '0;
      pass_d = 1'b0;
    end

    if (accept) begin
      vec_d             = vec_q + VEC_W'(1);
      cov_d[{in1, in2}] = 1'b1;
      if (out_dut != expected) begin
        if (err_q == '0) begin
          fidx_d = vec_q;
          fvec_d = {in1, in2, out_dut};
        end
        if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
      end
      if (vec_d == LAST_VEC) begin
        state_d = ST_DONE;
        pass_d  = (err_d == '0) && (cov_d == 4'hF);
      end
    end
  end

  assign sample_ready  = (state_q == ST_CHECK);
  assign busy          = (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign vec_count     = vec_q;
  assign first_err_idx = fidx_q;
  assign first_err_vec = fvec_q;
  assign coverage      = cov_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - self-checking bench for gate_response_checker
module tb_gate_response_checker;
  import gate_check_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, sample_valid = 1'b0;
  logic in1 = 1'b0, in2 = 1'b0, out_dut = 1'b0;

  logic       a_ready, a_busy, a_done, a_pass;
  logic [7:0] a_err;
  logic [4:0] a_vec, a_fidx;
  logic [2:0] a_fvec;
  logic [3:0] a_cov;

  logic       b_ready, b_busy, b_done, b_pass;
  logic [1:0] b_err;
  logic [3:0] b_vec, b_fidx;
  logic [2:0] b_fvec;
  logic [3:0] b_cov;

  gate_response_checker #(.GATE_OP(3'd4), .NUM_VECTORS(20), .ERR_W(8)) u_xor (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample_ready(a_ready),
    .in1(in1), .in2(in2), .out_dut(out_dut), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .vec_count(a_vec), .first_err_idx(a_fidx), .first_err_vec(a_fvec),
    .coverage(a_cov)
  );

  gate_response_checker #(.GATE_OP(3'd0), .NUM_VECTORS(8), .ERR_W(2)) u_and (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample_ready(b_ready),
    .in1(in1), .in2(in2), .out_dut(out_dut), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .vec_count(b_vec), .first_err_idx(b_fidx), .first_err_vec(b_fvec),
    .coverage(b_cov)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference: a run is a list of accepted samples summarised by count, mismatches, first miss, coverage.
  int       nv[2]   = '{20, 8};
  int       emax[2] = '{255, 3};
  int       ops[2]  = '{4, 0};
  int       m_n[2], m_mis[2], m_first[2], m_fvec[2], m_cov[2];
  bit       m_run[2], m_fin[2];

  function automatic bit ref_gate(int op, bit a, bit b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return !(a & b);
      3: return !(a | b);
      4: return a ^ b;
      5: return !(a ^ b);
      6: return a;
      default: return !a;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int d);
    m_n[d] = 0; m_mis[d] = 0; m_first[d] = -1; m_fvec[d] = 0; m_cov[d] = 0;
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_clear(d); m_run[d] = 0; m_fin[d] = 0;
      end else if (start) begin
        model_clear(d); m_run[d] = 1; m_fin[d] = 0;
      end else if (m_run[d] && sample_valid) begin
        if (out_dut != ref_gate(ops[d], in1, in2)) begin
          if (m_mis[d] == 0) begin
            m_first[d] = m_n[d];
            m_fvec[d]  = {in1, in2, out_dut};
          end
          m_mis[d]++;
        end
        m_n[d]++;
        m_cov[d] = m_cov[d] | (1 << {in1, in2});
        if (m_n[d] == nv[d]) begin
          m_run[d] = 0; m_fin[d] = 1;
        end
      end
    end
  endtask

  task automatic check_dut(input int d, input int rdy, input int bsy, input int dn, input int ps,
                           input int err, input int vec, input int fidx, input int fvec, input int cov);
    int e_err;
    e_err = (m_mis[d] > emax[d]) ? emax[d] : m_mis[d];
    chk($sformatf("d%0d_ready", d), rdy, int'(m_run[d]));
    chk($sformatf("d%0d_busy", d), bsy, int'(m_run[d]));
    chk($sformatf("d%0d_done", d), dn, int'(m_fin[d]));
    chk($sformatf("d%0d_pass", d), ps, int'(m_fin[d] && m_mis[d] == 0 && m_cov[d] == 15));
    chk($sformatf("d%0d_err", d), err, e_err);
    chk($sformatf("d%0d_vec", d), vec, m_n[d]);
    chk($sformatf("d%0d_fidx", d), fidx, (m_first[d] < 0) ? 0 : m_first[d]);
    chk($sformatf("d%0d_fvec", d), fvec, m_fvec[d]);
    chk($sformatf("d%0d_cov", d), cov, m_cov[d]);
  endtask

  task automatic step(input bit r, input bit s, input bit v, input bit a, input bit b, input bit o);
    rst = r; start = s; sample_valid = v; in1 = a; in2 = b; out_dut = o;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_dut(0, a_ready, a_busy, a_done, a_pass, a_err, a_vec, a_fidx, a_fvec, a_cov);
    check_dut(1, b_ready, b_busy, b_done, b_pass, b_err, b_vec, b_fidx, b_fvec, b_cov);
  endtask

  // pat 0: cycle 00,01,10,11; pat 1: always 01. fault: XOR DUT stuck-at-0 on (1,0).
  task automatic run_stream(input int pat, input bit fault, input int n);
    bit a, b, o;
    for (int i = 0; i < n; i++) begin
      a = (pat == 0) ? i[1] : 1'b0;
      b = (pat == 0) ? i[0] : 1'b1;
      o = (fault && a && !b) ? 1'b0 : (a ^ b);
      step(0, 0, 1, a, b, o);
    end
  endtask

  typedef struct {
    string name;
    int    pat;
    bit    fault;
    int    err;
    int    fidx;
    int    fvec;
    int    cov;
    int    pass;
  } vec_t;

  vec_t tbl[3];

  initial begin
    bit r, s, v, a, b, o;
    int x;

    tbl[0] = '{"xor_ideal", 0, 1'b0, 0, 0, 0, 15, 1};
    tbl[1] = '{"xor_fault", 0, 1'b1, 5, 2, 3'b100, 15, 0};
    tbl[2] = '{"xor_cov01", 1, 1'b0, 0, 0, 0, 4'b0010, 0};

    for (int d = 0; d < 2; d++) begin
      model_clear(d); m_run[d] = 0; m_fin[d] = 0;
    end
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_vec", a_vec, 0);

    step(0, 0, 1, 1, 0, 1);
    chk("idle_valid_vec", a_vec, 0);

    foreach (tbl[t]) begin
      step(0, 1, 0, 0, 0, 0);
      run_stream(tbl[t].pat, tbl[t].fault, 20);
      chk({tbl[t].name, "_done"}, a_done, 1);
      chk({tbl[t].name, "_err"}, a_err, tbl[t].err);
      chk({tbl[t].name, "_fidx"}, a_fidx, tbl[t].fidx);
      chk({tbl[t].name, "_fvec"}, a_fvec, tbl[t].fvec);
      chk({tbl[t].name, "_cov"}, a_cov, tbl[t].cov);
      chk({tbl[t].name, "_pass"}, a_pass, tbl[t].pass);
    end

    step(0, 0, 1, 0, 1, 0);
    chk("done_valid_vec", a_vec, 20);
    chk("done_valid_err", a_err, 0);

    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, 0);
    chk("sat_err", b_err, 3);
    chk("sat_fidx", b_fidx, 0);
    chk("sat_done", b_done, 1);
    chk("sat_pass", b_pass, 0);

    step(0, 1, 0, 0, 0, 0);
    run_stream(0, 1'b1, 7);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_vec", a_vec, 0);
    chk("rst_mid_err", a_err, 0);
    chk("rst_mid_cov", a_cov, 0);

    step(0, 1, 0, 0, 0, 0);
    run_stream(0, 1'b1, 5);
    step(0, 1, 1, 1, 0, 0);
    chk("restart_vec", a_vec, 0);
    chk("restart_busy", a_busy, 1);
    chk("restart_err", a_err, 0);

    run_stream(0, 1'b1, 20);
    chk("b2b_pre_done", a_done, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("b2b_done", a_done, 0);
    chk("b2b_busy", a_busy, 1);
    chk("b2b_err", a_err, 0);
    chk("b2b_vec", a_vec, 0);

    for (int i = 0; i < 2000; i++) begin
      x = $urandom_range(0, 99);
      r = (x < 1);
      s = (x >= 1 && x < 4);
      v = ($urandom_range(0, 3) != 0);
      a = 1'($urandom);
      b = 1'($urandom);
      o = ($urandom_range(0, 9) < 8) ? (a ^ b) : 1'($urandom);
      step(r, s, v, a, b, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
